// File: rtl/helloworld_response_capture_pkg.sv
// Shared definitions for the HelloWorld response capture block: FSM state
// encoding, bit positions of the netlist outputs inside resp_i and the
// default MISR seed/polynomial.
package helloworld_cap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int Z0RE  = 0;
  localparam int Z1RE  = 1;
  localparam int Z2RE  = 2;
  localparam int Z3RE  = 3;
  localparam int Z4RE  = 4;
  localparam int Z5RE  = 5;
  localparam int Z50AL = 6;
  localparam int Z51AL = 7;
  localparam int U34FE = 8;
  localparam int U35FE = 9;
  localparam int U36FE = 10;
  localparam int U37AH = 11;
  localparam int U38AH = 12;
  localparam int U39AH = 13;
  localparam int N44   = 14;
  localparam int TEST  = 15;

  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;
  // x^16 + x^5 + x^3 + x^2 + 1
  localparam logic [15:0] DEFAULT_POLY = 16'h002D;

endpackage

// File: rtl/helloworld_response_capture_if.sv
// Bundle of the capture block's data and handshake signals. The master side
// (controller / bench) drives the netlist response and the start/ack
// handshake; the slave side (capture block) returns status and results.
interface helloworld_response_capture_if
  import helloworld_cap_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int CNT_W = 16
);

  logic [15:0]      resp_i;
  logic             start_i;
  logic [LEN_W-1:0] len_i;
  logic             ack_i;
  logic             busy_o;
  logic             done_o;
  logic [15:0]      sig_o;
  logic [CNT_W-1:0] toggles_o;

  modport master (
    output resp_i, start_i, len_i, ack_i,
    input  busy_o, done_o, sig_o, toggles_o
  );

  modport slave (
    input  resp_i, start_i, len_i, ack_i,
    output busy_o, done_o, sig_o, toggles_o
  );

endinterface

// File: rtl/helloworld_response_capture_misr16.sv
// 16-bit multiple-input signature register. Shifts left with feedback taps
// from POLY whenever enabled and folds the parallel input word in. A load
// returns it to SEED so each capture starts from a known signature.
module misr16
  import helloworld_cap_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED,
  parameter logic [15:0] POLY = DEFAULT_POLY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] data,
  output logic [15:0] sig
);

  // Signature register: seed on reset/load, one compression step when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[14:0], 1'b0} ^ (sig[15] ? POLY : 16'h0000) ^ data;
    end
  end

endmodule

// File: rtl/helloworld_response_capture.sv
// Captures a window of HelloWorld netlist outputs: after an optional settle
// delay it compresses len_i consecutive response words into a MISR signature
// and counts how many of them differ from the preceding cycle's word.
// Results are held through DONE and remain readable in IDLE until the next
// capture is started.
module helloworld_response_capture
  import helloworld_cap_pkg::*;
#(
  parameter int          SETTLE = 4,
  parameter int          LEN_W  = 16,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  parameter logic [15:0] POLY   = DEFAULT_POLY
) (
  input logic                          bertaClock,
  input logic                          global_reset,
  helloworld_response_capture_if.slave bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  cap_state_t       state;
  cap_state_t       state_next;
  logic             seed_load;
  logic             cap_en;
  logic [SW-1:0]    settle_cnt;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] toggles;
  logic [15:0]      prev;
  logic [15:0]      sig;

  // State register.
  always_ff @(posedge bertaClock or posedge global_reset) begin
    if (global_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes that seed a capture and enable compression.
  always_comb begin
    state_next = state;
    seed_load  = 1'b0;
    cap_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          seed_load = 1'b1;
          if (bus.len_i == '0) begin
            state_next = ST_DONE;
          end else if (SETTLE == 0) begin
            state_next = ST_CAPTURE;
          end else begin
            state_next = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        cap_en = 1'b1;
        if (remaining == LEN_W'(1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ack_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Settle/length counters, saturating toggle counter and the previous-word register.
  always_ff @(posedge bertaClock or posedge global_reset) begin
    if (global_reset) begin
      settle_cnt <= '0;
      remaining  <= '0;
      toggles    <= '0;
      prev       <= '0;
    end else begin
      prev <= bus.resp_i;
      if (seed_load) begin
        settle_cnt <= '0;
        remaining  <= bus.len_i;
        toggles    <= '0;
      end else begin
        if (state == ST_SETTLE) begin
          settle_cnt <= settle_cnt + 1'b1;
        end
        if (cap_en) begin
          remaining <= remaining - 1'b1;
          if ((bus.resp_i != prev) && (toggles != {CNT_W{1'b1}})) begin
            toggles <= toggles + 1'b1;
          end
        end
      end
    end
  end

  misr16 #(
    .SEED(SEED),
    .POLY(POLY)
  ) u_misr (
    .clk  (bertaClock),
    .rst  (global_reset),
    .load (seed_load),
    .en   (cap_en),
    .data (bus.resp_i),
    .sig  (sig)
  );

  assign bus.busy_o    = (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign bus.done_o    = (state == ST_DONE);
  assign bus.sig_o     = sig;
  assign bus.toggles_o = toggles;

endmodule
